tdc_thermo_decoder: RTL and testbench

TDC_THERMO_DECODER -- requirements
Module: tdc_thermo_decoder

---
 rtl/tdc_thermo_decoder.sv | 174 +++++++++++++++++
 tb/tb_tdc_thermo_decoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_thermo_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_thermo_decoder
//  Description : Time-to-digital converter back end. Samples a thermometer
//                coded carry-chain delay line, bubble-corrects it with a
//                3-tap majority filter, counts the corrected ones as the fine
//                code and pairs it with a free-running coarse cycle counter.
//                A small IDLE/ARMED/HOLD controller accepts one hit per arm
//                request and holds the result until it is handshaken out.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    taps       in   [LENGTH-1:0] thermometer taps, bit 0 nearest the start
//    arm        in   single-cycle request to accept the next hit
//    out_ready  in   consumer accepts the held result
//    out_valid  out  result present on coarse/fine
//    coarse     out  [COARSE_W-1:0] counter value of the hit sample cycle
//    fine       out  [FINE_W-1:0] bubble-corrected ones count of the hit
//    armed      out  waiting for a hit
//    missed     out  sticky: a hit arrived while a result was pending
// ============================================================================
module tdc_thermo_decoder #(
    parameter  int LENGTH   = 8,
    parameter  int COARSE_W = 16,
    localparam int FINE_W   = $clog2(LENGTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LENGTH-1:0]   taps,
    input  logic                arm,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [COARSE_W-1:0] coarse,
    output logic [FINE_W-1:0]   fine,
    output logic                armed,
    output logic                missed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [COARSE_W-1:0] cnt;
    logic [LENGTH-1:0]   t1;
    logic [LENGTH-1:0]   t1_prev;
    logic [COARSE_W-1:0] c1;
    logic [LENGTH-1:0]   cor;
    logic [FINE_W-1:0]   fine_calc;
    logic                hit;

    // Second pipeline stage: the controller acts on the hit two edges after
    // the taps were sampled, giving the registered popcount a full cycle.
    logic                s2_hit;
    logic [FINE_W-1:0]   s2_fine;
    logic [COARSE_W-1:0] s2_coarse;

    // ------------------------------------------------------------------------
    // Bubble correction: 3-tap majority with the end taps replicated.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < LENGTH; i++) begin : g_cor
        logic lo;
        logic hi;
        if (i == 0) begin : g_lo_edge
            assign lo = t1[0];
        end else begin : g_lo_mid
            assign lo = t1[i-1];
        end
        if (i == LENGTH - 1) begin : g_hi_edge
            assign hi = t1[LENGTH-1];
        end else begin : g_hi_mid
            assign hi = t1[i+1];
        end
        assign cor[i] = (lo & t1[i]) | (lo & hi) | (t1[i] & hi);
    end

    always_comb begin
        fine_calc = '0;
        for (int i = 0; i < LENGTH; i++) begin
            fine_calc = fine_calc + FINE_W'(cor[i]);
        end
    end

    // Only the zero-to-nonzero transition of the sampled chain is a hit.
    assign hit = (t1_prev == '0) && (t1 != '0);

    // ------------------------------------------------------------------------
    // Counter and sampling pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            t1        <= '0;
            t1_prev   <= '0;
            c1        <= '0;
            s2_hit    <= 1'b0;
            s2_fine   <= '0;
            s2_coarse <= '0;
        end else begin
            cnt       <= cnt + COARSE_W'(1);
            t1        <= taps;
            t1_prev   <= t1;
            c1        <= cnt;
            s2_hit    <= hit;
            s2_fine   <= fine_calc;
            s2_coarse <= c1;
        end
    end

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // A simultaneous hit is deliberately dropped here.
                if (arm) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (s2_hit) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers only load on the ARMED->HOLD transition, so they stay
    // stable for the whole HOLD period regardless of later hits or wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse <= '0;
            fine   <= '0;
            missed <= 1'b0;
        end else begin
            if (state == ARMED && s2_hit) begin
                coarse <= s2_coarse;
                fine   <= s2_fine;
            end
            if (state == IDLE && arm) begin
                missed <= 1'b0;
            end else if (state == HOLD && s2_hit) begin
                missed <= 1'b1;
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign armed     = (state == ARMED);

endmodule
`default_nettype wire

// File: tb/tb_tdc_thermo_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_thermo_decoder
//  Description : Self-checking bench for tdc_thermo_decoder (LENGTH=8,
//                COARSE_W=16). Directed table, hand sequences and random
//                stimulus compared with an event-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_thermo_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  taps;
    logic        arm;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] coarse;
    logic [3:0]  fine;
    logic        armed;
    logic        missed;

    tdc_thermo_decoder #(.LENGTH(8), .COARSE_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .taps      (taps),
        .arm       (arm),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .coarse    (coarse),
        .fine      (fine),
        .armed     (armed),
        .missed    (missed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: keeps the whole tap history since reset, indexed by
    // edge number, and applies the behavioural rules to it.
    // ------------------------------------------------------------------------
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_HOLD  = 2;

    int          e;           // edges since reset release
    logic [7:0]  hist[$];     // hist[k] = taps sampled at edge k, hist[0] = 0
    int          m_mode;
    logic [15:0] m_coarse;
    logic [3:0]  m_fine;
    logic        m_missed;

    function automatic int fine_of(input logic [7:0] t);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            int lo = (i == 0) ? int'(t[0]) : int'(t[i-1]);
            int hi = (i == 7) ? int'(t[7]) : int'(t[i+1]);
            if (lo + int'(t[i]) + hi >= 2) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        e = 0;
        hist.delete();
        hist.push_back(8'h00);
        m_mode   = M_IDLE;
        m_coarse = '0;
        m_fine   = '0;
        m_missed = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] tp, input logic a, input logic r);
        int  k;
        bit  h;
        e++;
        hist.push_back(tp);
        k = e - 2;
        h = (k >= 1) && (hist[k] != 0) && (hist[k-1] == 0);
        case (m_mode)
            M_IDLE: if (a) begin
                m_mode   = M_ARMED;
                m_missed = 1'b0;
            end
            M_ARMED: if (h) begin
                m_mode   = M_HOLD;
                m_coarse = 16'((k - 1) % 65536);
                m_fine   = 4'(fine_of(hist[k]));
            end
            default: begin
                if (h) m_missed = 1'b1;
                if (r) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(m_mode == M_HOLD));
        chk("armed",     32'(armed),     32'(m_mode == M_ARMED));
        chk("missed",    32'(missed),    32'(m_missed));
        chk("coarse",    32'(coarse),    32'(m_coarse));
        chk("fine",      32'(fine),      32'(m_fine));
    endtask

    task automatic step(input logic [7:0] tp, input logic a, input logic r);
        @(negedge clk);
        taps      = tp;
        arm       = a;
        out_ready = r;
        @(posedge clk);
        model_edge(tp, a, r);
        #1;
        check_model();
    endtask

    // ------------------------------------------------------------------------
    // Directed table: first results after reset
    // ------------------------------------------------------------------------
    typedef struct {
        logic [7:0]  tp;
        logic        a;
        logic        r;
        logic        v;
        logic        arm_q;
        logic [15:0] c;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [7:0] rand_taps();
        int          n;
        logic [7:0]  p;
        logic [7:0]  one;
        if ($urandom_range(0, 2) == 0) return 8'h00;
        n = $urandom_range(0, 8);
        p = (n == 8) ? 8'hFF : 8'((1 << n) - 1);
        if ($urandom_range(0, 3) == 0) begin
            one = 8'h01;
            p = p ^ (one << $urandom_range(0, 7));
        end
        return p;
    endfunction

    initial begin
        int vcount;

        tbl[0]  = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'd0};
        tbl[1]  = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'd0};
        tbl[2]  = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 4'd3};
        tbl[3]  = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 4'd3};
        tbl[4]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 4'd3};
        tbl[5]  = '{8'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 4'd3};
        tbl[6]  = '{8'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 4'd3};
        tbl[7]  = '{8'h0B, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0015, 4'd3};
        tbl[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0015, 4'd3};
        tbl[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0015, 4'd3};
        tbl[10] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0015, 4'd3};
        tbl[11] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0015, 4'd3};
        tbl[12] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h001A, 4'd8};
        tbl[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h001A, 4'd8};

        // Reset state
        rst_n = 1'b0; taps = 8'h00; arm = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_armed",     32'(armed),     32'd0);
        chk("rst_missed",    32'(missed),    32'd0);
        chk("rst_coarse",    32'(coarse),    32'd0);
        chk("rst_fine",      32'(fine),      32'd0);
        #1 rst_n = 1'b1;
        model_reset();

        // Arm on edge 1, idle until the hit sampled at counter 0x0010
        step(8'h00, 1'b1, 1'b0);
        repeat (15) step(8'h00, 1'b0, 1'b0);
        foreach (tbl[i]) begin
            step(tbl[i].tp, tbl[i].a, tbl[i].r);
            chk("tbl_valid",  32'(out_valid), 32'(tbl[i].v));
            chk("tbl_armed",  32'(armed),     32'(tbl[i].arm_q));
            chk("tbl_coarse", 32'(coarse),    32'(tbl[i].c));
            chk("tbl_fine",   32'(fine),      32'(tbl[i].f));
        end

        // Pending result, second hit becomes a miss, handshake, re-arm clears
        step(8'h00, 1'b1, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        chk("miss_valid", 32'(out_valid), 32'd1);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        chk("miss_set",   32'(missed),    32'd1);
        chk("miss_fine",  32'(fine),      32'd2);
        step(8'h00, 1'b0, 1'b1);
        chk("miss_idle",  32'(out_valid), 32'd0);
        chk("miss_stick", 32'(missed),    32'd1);
        step(8'h00, 1'b1, 1'b0);
        chk("miss_clear", 32'(missed),    32'd0);

        // Chain held nonzero while armed yields exactly one result
        step(8'h00, 1'b0, 1'b0);
        vcount = 0;
        repeat (10) begin
            step(8'h0F, 1'b0, 1'b1);
            if (out_valid) vcount++;
        end
        repeat (3) begin
            step(8'h00, 1'b0, 1'b1);
            if (out_valid) vcount++;
        end
        chk("held_one_result", 32'(vcount), 32'd1);

        // Hit in IDLE ignored; arm on a held chain waits for a fresh rise
        step(8'h07, 1'b0, 1'b0);
        repeat (3) step(8'h07, 1'b0, 1'b0);
        chk("idle_hit_ignored", 32'(out_valid), 32'd0);
        step(8'h07, 1'b1, 1'b0);
        repeat (4) step(8'h07, 1'b0, 1'b0);
        chk("held_no_capture", 32'(out_valid), 32'd0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        chk("fresh_rise_capture", 32'(out_valid), 32'd1);
        step(8'h00, 1'b0, 1'b1);

        // Random traffic against the model
        repeat (1500) begin
            step(rand_taps(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        // Hit sampled at counter 0xFFFF, read out after the wrap
        while (e < 65532) step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        chk("wrap_valid",  32'(out_valid), 32'd1);
        chk("wrap_coarse", 32'(coarse),    32'h0000FFFF);
        chk("wrap_fine",   32'(fine),      32'd2);
        step(8'h03, 1'b0, 1'b0);
        chk("wrap_hold",   32'(coarse),    32'h0000FFFF);

        // Reset during HOLD drops the result at once
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hold_valid",  32'(out_valid), 32'd0);
        chk("rst_hold_coarse", 32'(coarse),    32'd0);
        chk("rst_hold_fine",   32'(fine),      32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        chk("post_rst_valid",  32'(out_valid), 32'd1);
        chk("post_rst_coarse", 32'(coarse),    32'd2);
        chk("post_rst_fine",   32'(fine),      32'd1);
        step(8'h00, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
